// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register with a two-entry skid buffer.
// in_ready depends only on local state and freeze, never on out_ready,
// so chained stages do not build long combinational ready paths.
// Freeze holds everything. Flush squashes all held entries. A saturating
// counter reports how many cycles a held entry waited.
module pipe_stage_skid_reg #(
    parameter int WIDTH          = 32,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             push, pop;

    assign in_ready  = (state != TWO) && !freeze;
    assign out_valid = (state != EMPTY) && !freeze;
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Map the FSM state onto an entry count.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next state and data. Flush beats freeze, and freeze beats any transfer.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_n = '0;
                skid_n = '0;
            end
        end else if (!freeze) begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_n  = in_data;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_n = in_data;
                    end else if (push) begin
                        skid_n  = in_data;
                        state_n = TWO;
                    end else if (pop) begin
                        // main keeps its last value. out_data is don't-care when invalid.
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen. The skid entry moves up.
                    if (pop) begin
                        main_n  = skid_q;
                        state_n = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    // Count edges where something is held but does not leave.
    // Frozen cycles count. Flush edges do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && (state != EMPTY) && !pop && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
